mmio_bus: RTL

Memory-side bus splitter and MMIO peripheral block that sits directly downstream of the single-cycle CPU's data-memory port. It decodes `mem_addr` and either passes accesses through to the data memory or services a small MMIO register file. The register file holds an output word FIFO drained by the PDU, a latched input word from the PDU, an LED register and an optional cycle counter. All reads are combinational, so a load completes in the CPU's single cycle. All writes and state changes occur on the rising clock edge.

---
 rtl/mmio_bus.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mmio_bus.sv
// Memory-side bus splitter with an MMIO block: output word FIFO, latched input word, LED register.
// Optional free-running CYCLE counter is built only when MMIO_CYCLE_CNT_EN is defined.
module mmio_bus #(
    parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic [15:0] led
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              is_mmio;
    logic [29:0]       word_off;
    logic              wr_mmio;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              clr_ovf;
    logic              clr_in;
    logic              wr_led;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    logic              in_full;
    logic              overrun;
    logic [31:0]       in_word;

    logic [31:0]       cycle_val;
    logic [31:0]       out_status;
    logic [31:0]       rd_data;

    // Register index is the word distance from the MMIO base; byte lanes are ignored.
    assign is_mmio  = (mem_addr >= MMIO_BASE);
    assign word_off = mem_addr[31:2] - MMIO_BASE[31:2];
    assign wr_mmio  = mem_we & is_mmio;

    assign push_req = wr_mmio & (word_off == 30'd0);
    assign clr_ovf  = wr_mmio & (word_off == 30'd1);
    assign clr_in   = wr_mmio & (word_off == 30'd2);
    assign wr_led   = wr_mmio & (word_off == 30'd4);

    assign dm_addr  = mem_addr;
    assign dm_din   = mem_din;
    assign dm_we    = mem_we & ~is_mmio;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = push_req & ~fifo_full;
    assign pop        = out_valid & out_ready;
    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_mem[rd_ptr];

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // A strobe coinciding with a status clear keeps the new word and drops the stale overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_full <= 1'b0;
            overrun <= 1'b0;
            in_word <= '0;
        end else if (in_valid) begin
            in_word <= in_data;
            in_full <= 1'b1;
            overrun <= clr_in ? 1'b0 : (overrun | in_full);
        end else if (clr_in) begin
            in_full <= 1'b0;
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= '0;
        end else if (wr_led) begin
            led <= mem_din[15:0];
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic        wr_cycle;
    logic [31:0] cycle_cnt;

    assign wr_cycle = wr_mmio & (word_off == 30'd5);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (wr_cycle) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = 32'd0;
`endif

    assign out_status = {16'd0, 8'(count), 5'd0, overflow, fifo_empty, ~fifo_full};

    always_comb begin
        rd_data = dm_dout;
        if (is_mmio) begin
            case (word_off)
                30'd1:   rd_data = out_status;
                30'd2:   rd_data = {30'd0, overrun, in_full};
                30'd3:   rd_data = in_word;
                30'd4:   rd_data = {16'd0, led};
                30'd5:   rd_data = cycle_val;
                default: rd_data = 32'd0;
            endcase
        end
    end

    assign mem_dout = rd_data;

endmodule
